// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared constants and types for the Sobel 3x3 window generator.
//   PIX_W      : pixel width in bits
//   COORD_W    : width of the optional window-centre coordinate outputs
//   IMG_W_DEF  : default pixels per line
//   IMG_H_DEF  : default lines per frame
//   win_col_t  : one vertical column of the 3x3 window (top = oldest row)
//   addr_w()   : counter/address width for a given depth (minimum 1 bit)
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int COORD_W   = 10;
    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 48;

    typedef struct packed {
        logic [PIX_W-1:0] top;  // row r-2
        logic [PIX_W-1:0] mid;  // row r-1
        logic [PIX_W-1:0] bot;  // row r
    } win_col_t;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// -----------------------------------------------------------------------------
// sobel_line_buf
// One line of pixel storage: single-port RAM, synchronous read-before-write.
// On a cycle with en=1 the old content at addr is captured into rdata and,
// if we=1, the same location is overwritten with wdata.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears only the read register)
//   en    : port enable; rdata holds its value when en=0
//   we    : write enable (qualified by en)
//   addr  : column index
//   wdata : pixel to store
//   rdata : previous content of addr, valid the cycle after en
// -----------------------------------------------------------------------------
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rdata_reg;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register sees the pre-write content (read-before-write). It is
    // reset so that the window outputs fed from it start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (en) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
// Streams raster-order pixels in and emits the 3x3 neighbourhood (minus the
// centre) of every pixel that has a full window, i.e. row >= 2 and col >= 2.
// Output latency is one cycle from the accepted pixel to out_valid.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_pix, in_sof        : pixel and start-of-frame, qualified by in_valid
//   in_valid / in_ready   : upstream handshake, in_ready = !out_valid || out_ready
//   p0..p3, p5..p8        : window (p0 = (r-2,c-2) ... p8 = (r,c))
//   out_valid / out_ready : downstream handshake
//   frame_done            : one-cycle pulse after the last window of a frame
//                           has been taken downstream
//   out_x, out_y          : window centre (c-1, r-1), only when the macro
//                           SOBEL_WIN_COORD_EN is defined
//
// Line storage uses two single-port buffers in ping-pong: row r is written
// into buffer r[0], so at row r that buffer still holds row r-2 (read before
// being overwritten) and the other buffer holds row r-1. The buffers' read
// registers act directly as the top two cells of the window's right column.
// -----------------------------------------------------------------------------
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   in_pix,
    input  logic               in_sof,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [PIX_W-1:0]   p0,
    output logic [PIX_W-1:0]   p1,
    output logic [PIX_W-1:0]   p2,
    output logic [PIX_W-1:0]   p3,
    output logic [PIX_W-1:0]   p5,
    output logic [PIX_W-1:0]   p6,
    output logic [PIX_W-1:0]   p7,
    output logic [PIX_W-1:0]   p8,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_done
`ifdef SOBEL_WIN_COORD_EN
    ,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y
`endif
);

    localparam int CW = addr_w(IMG_W);
    localparam int RW = addr_w(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    // Position counters
    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;
    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_row;

    logic accept;
    logic win_hit;
    logic last_hit;

    // Window state
    win_col_t         left_reg;
    win_col_t         mid_reg;
    win_col_t         right_col;
    logic [PIX_W-1:0] bot_reg;
    logic             parity_reg;

    logic             out_valid_reg;
    logic             last_reg;
    logic             frame_done_reg;

    // Line buffers
    logic [1:0]       lb_we;
    logic [PIX_W-1:0] lb_rdata [2];

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // An accepted start-of-frame pixel is position (0,0) regardless of where
    // the counters were; everything downstream uses the effective position.
    always_comb begin
        eff_col  = in_sof ? '0 : col_reg;
        eff_row  = in_sof ? '0 : row_reg;
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (eff_col == COL_LAST) begin
                col_next = '0;
                row_next = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col_next = eff_col + 1'b1;
                row_next = eff_row;
            end
        end
        win_hit  = (eff_row >= ROW_MIN) && (eff_col >= COL_MIN);
        last_hit = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lb
            // Only the buffer matching the current row parity is written;
            // both are read every accept.
            assign lb_we[gi] = accept && (eff_row[0] == 1'(gi));

            sobel_line_buf #(
                .DEPTH (IMG_W)
            ) u_lb (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (accept),
                .we    (lb_we[gi]),
                .addr  (eff_col),
                .wdata (in_pix),
                .rdata (lb_rdata[gi])
            );
        end
    endgenerate

    // Right column of the current window. parity_reg is the row parity of
    // the last accepted pixel: its own buffer returned row r-2, the other
    // buffer returned row r-1.
    always_comb begin
        right_col.top = lb_rdata[parity_reg];
        right_col.mid = lb_rdata[~parity_reg];
        right_col.bot = bot_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg        <= '0;
            row_reg        <= '0;
            left_reg       <= '0;
            mid_reg        <= '0;
            bot_reg        <= '0;
            parity_reg     <= 1'b0;
            out_valid_reg  <= 1'b0;
            last_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
            if (accept) begin
                // Shift columns left; the RAM read registers load the new
                // right column top/mid on this same edge.
                left_reg      <= mid_reg;
                mid_reg       <= right_col;
                bot_reg       <= in_pix;
                parity_reg    <= eff_row[0];
                out_valid_reg <= win_hit;
                last_reg      <= win_hit && last_hit;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // Pulse once the final window of the frame is handed over. A
            // mid-frame restart never carries last_reg, so it cannot pulse.
            frame_done_reg <= out_valid_reg && out_ready && last_reg;
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    logic [COORD_W-1:0] out_x_reg;
    logic [COORD_W-1:0] out_y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x_reg <= '0;
            out_y_reg <= '0;
        end else if (accept && win_hit) begin
            out_x_reg <= COORD_W'(eff_col) - 1'b1;
            out_y_reg <= COORD_W'(eff_row) - 1'b1;
        end
    end

    assign out_x = out_x_reg;
    assign out_y = out_y_reg;
`endif

    assign p0 = left_reg.top;
    assign p3 = left_reg.mid;
    assign p6 = left_reg.bot;
    assign p1 = mid_reg.top;
    assign p7 = mid_reg.bot;
    assign p2 = right_col.top;
    assign p5 = right_col.mid;
    assign p8 = right_col.bot;

    assign out_valid  = out_valid_reg;
    assign frame_done = frame_done_reg;

endmodule
